// File: rtl/rtc_calendar_multi_alarm.sv
// rtc_calendar_multi_alarm
// Time-of-day and Gregorian calendar driven by an internal seconds prescaler,
// with NUM_ALARMS latched alarm channels, a mm:ss countdown timer and
// validated time/date loading.
// Optional feature macro: RTC_SNOOZE_EN (adds per-channel alarm_snooze input).
module rtc_calendar_multi_alarm #(
    parameter int CLK_DIV      = 1,
    parameter int NUM_ALARMS   = 4,
    parameter int YEAR_MIN     = 2020,
    parameter int YEAR_MAX     = 2099,
    parameter int YEAR_MIN_DOW = 3,
    parameter int SNOOZE_MIN   = 5,
    localparam int IDX_W       = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic [4:0]            set_hour,
    input  logic [5:0]            set_min,
    input  logic [5:0]            set_sec,
    input  logic [4:0]            set_day,
    input  logic [3:0]            set_month,
    input  logic [11:0]           set_year,
    input  logic [2:0]            set_dow,
    output logic                  set_err,
    input  logic                  alarm_wr,
    input  logic [IDX_W-1:0]      alarm_idx,
    input  logic [4:0]            alarm_hour,
    input  logic [5:0]            alarm_min,
    input  logic [5:0]            alarm_sec,
    input  logic                  alarm_en_in,
    input  logic [NUM_ALARMS-1:0] alarm_ack,
`ifdef RTC_SNOOZE_EN
    input  logic [NUM_ALARMS-1:0] alarm_snooze,
`endif
    input  logic                  timer_load,
    input  logic                  timer_start,
    input  logic                  timer_pause,
    input  logic [5:0]            timer_min,
    input  logic [5:0]            timer_sec,
    output logic [4:0]            hour,
    output logic [5:0]            min,
    output logic [5:0]            sec,
    output logic [3:0]            hour12,
    output logic                  pm,
    output logic [4:0]            day,
    output logic [3:0]            month,
    output logic [11:0]           year,
    output logic [2:0]            day_of_week,
    output logic                  sec_pulse,
    output logic [NUM_ALARMS-1:0] alarm_ring,
    output logic [5:0]            timer_count_min,
    output logic [5:0]            timer_count_sec,
    output logic [1:0]            timer_state,
    output logic                  timer_done
);

    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_RUN   = 2'd1,
        T_PAUSE = 2'd2,
        T_DONE  = 2'd3
    } tstate_t;

    function automatic logic is_leap(input logic [11:0] y);
        return (((y % 12'd4) == 12'd0) && ((y % 12'd100) != 12'd0)) ||
               ((y % 12'd400) == 12'd0);
    endfunction

    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [11:0] y);
        case (m)
            4'd2:                      return is_leap(y) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
            default:                   return 5'd31;
        endcase
    endfunction

    logic [PRE_W-1:0] presc_q, presc_d;
    logic [5:0]       sec_q, sec_d, min_q, min_d;
    logic [4:0]       hour_q, hour_d, day_q, day_d;
    logic [3:0]       month_q, month_d;
    logic [11:0]      year_q, year_d;
    logic [2:0]       dow_q, dow_d;
    logic             sec_pulse_q, sec_pulse_d;
    logic             set_err_q, set_err_d;

    logic             tick, tick_eff, set_valid;
    logic [4:0]       dim_cur;

    tstate_t          tstate_q, tstate_d;
    logic [5:0]       tmin_q, tmin_d, tsec_q, tsec_d;
    logic             tdone_q, tdone_d;

    assign tick     = (presc_q == PRE_W'(CLK_DIV - 1));
    assign dim_cur  = days_in_month(month_q, year_q);
    assign set_valid = set_en &&
                       (set_hour <= 5'd23) && (set_min <= 6'd59) && (set_sec <= 6'd59) &&
                       (set_month >= 4'd1) && (set_month <= 4'd12) &&
                       (set_day >= 5'd1) && (set_day <= days_in_month(set_month, set_year)) &&
                       (set_year >= 12'(YEAR_MIN)) && (set_year <= 12'(YEAR_MAX)) &&
                       (set_dow <= 3'd6);
    // A valid load owns the cycle; an invalid one lets the tick proceed.
    assign tick_eff = tick && !set_valid;

    // Next-state for prescaler, time of day and calendar rollover chain.
    always_comb begin
        presc_d     = tick ? '0 : presc_q + PRE_W'(1);
        sec_d       = sec_q;
        min_d       = min_q;
        hour_d      = hour_q;
        day_d       = day_q;
        month_d     = month_q;
        year_d      = year_q;
        dow_d       = dow_q;
        sec_pulse_d = tick_eff;
        set_err_d   = set_en && !set_valid;
        if (set_valid) begin
            presc_d = '0;
            sec_d   = set_sec;
            min_d   = set_min;
            hour_d  = set_hour;
            day_d   = set_day;
            month_d = set_month;
            year_d  = set_year;
            dow_d   = set_dow;
        end else if (tick) begin
            if (sec_q != 6'd59) begin
                sec_d = sec_q + 6'd1;
            end else begin
                sec_d = 6'd0;
                if (min_q != 6'd59) begin
                    min_d = min_q + 6'd1;
                end else begin
                    min_d = 6'd0;
                    if (hour_q != 5'd23) begin
                        hour_d = hour_q + 5'd1;
                    end else begin
                        hour_d = 5'd0;
                        dow_d  = (dow_q == 3'd6) ? 3'd0 : dow_q + 3'd1;
                        if (day_q != dim_cur) begin
                            day_d = day_q + 5'd1;
                        end else begin
                            day_d = 5'd1;
                            if (month_q != 4'd12) begin
                                month_d = month_q + 4'd1;
                            end else begin
                                month_d = 4'd1;
                                if (year_q == 12'(YEAR_MAX)) begin
                                    year_d = 12'(YEAR_MIN);
                                    dow_d  = 3'(YEAR_MIN_DOW);
                                end else begin
                                    year_d = year_q + 12'd1;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    // Clock/calendar registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q     <= '0;
            sec_q       <= 6'd0;
            min_q       <= 6'd0;
            hour_q      <= 5'd0;
            day_q       <= 5'd1;
            month_q     <= 4'd1;
            year_q      <= 12'(YEAR_MIN);
            dow_q       <= 3'(YEAR_MIN_DOW);
            sec_pulse_q <= 1'b0;
            set_err_q   <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            day_q       <= day_d;
            month_q     <= month_d;
            year_q      <= year_d;
            dow_q       <= dow_d;
            sec_pulse_q <= sec_pulse_d;
            set_err_q   <= set_err_d;
        end
    end

    // Alarm channels: programmable time/enable and a latched ring flag each.
    generate
        for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_alarm
            logic [4:0] ah_q, ah_d;
            logic [5:0] am_q, am_d, as_q, as_d;
            logic       aen_q, aen_d, ring_q, ring_d;
            logic       wr_sel, match, snz_hit, snz_clr;

            assign wr_sel = alarm_wr && (alarm_idx == IDX_W'(gi));
            // Only a real second advance can match, so loading the time never rings.
            assign match  = sec_pulse_q && aen_q &&
                            (hour_q == ah_q) && (min_q == am_q) && (sec_q == as_q);

`ifdef RTC_SNOOZE_EN
            logic       pend_q, pend_d;
            logic [4:0] sh_q, sh_d;
            logic [5:0] sm_q, sm_d, ss_q, ss_d;
            logic [6:0] snz_sum;

            assign snz_sum = {1'b0, min_q} + 7'(SNOOZE_MIN % 60);
            assign snz_clr = alarm_snooze[gi] && ring_q;
            assign snz_hit = sec_pulse_q && pend_q &&
                             (hour_q == sh_q) && (min_q == sm_q) && (sec_q == ss_q);

            // Snooze bookkeeping: target time SNOOZE_MIN later, one re-ring per snooze.
            always_comb begin
                pend_d = pend_q;
                sh_d   = sh_q;
                sm_d   = sm_q;
                ss_d   = ss_q;
                if (snz_hit) begin
                    pend_d = 1'b0;
                end
                if (snz_clr) begin
                    pend_d = 1'b1;
                    ss_d   = sec_q;
                    if (snz_sum >= 7'd60) begin
                        sm_d = 6'(snz_sum - 7'd60);
                        sh_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                    end else begin
                        sm_d = snz_sum[5:0];
                        sh_d = hour_q;
                    end
                end
                if (alarm_ack[gi] || wr_sel) begin
                    pend_d = 1'b0;
                end
            end

            // Snooze registers.
            always_ff @(posedge clk) begin
                if (reset) begin
                    pend_q <= 1'b0;
                    sh_q   <= 5'd0;
                    sm_q   <= 6'd0;
                    ss_q   <= 6'd0;
                end else begin
                    pend_q <= pend_d;
                    sh_q   <= sh_d;
                    sm_q   <= sm_d;
                    ss_q   <= ss_d;
                end
            end
`else
            assign snz_clr = 1'b0;
            assign snz_hit = 1'b0;
`endif

            // Channel write and ring latch; a fresh match beats a same-cycle ack.
            always_comb begin
                ah_d   = ah_q;
                am_d   = am_q;
                as_d   = as_q;
                aen_d  = aen_q;
                ring_d = ring_q;
                if (alarm_ack[gi] || snz_clr) begin
                    ring_d = 1'b0;
                end
                if (wr_sel) begin
                    ah_d   = alarm_hour;
                    am_d   = alarm_min;
                    as_d   = alarm_sec;
                    aen_d  = alarm_en_in;
                    ring_d = 1'b0;
                end
                if (match || snz_hit) begin
                    ring_d = 1'b1;
                end
            end

            // Channel registers.
            always_ff @(posedge clk) begin
                if (reset) begin
                    ah_q   <= 5'd0;
                    am_q   <= 6'd0;
                    as_q   <= 6'd0;
                    aen_q  <= 1'b0;
                    ring_q <= 1'b0;
                end else begin
                    ah_q   <= ah_d;
                    am_q   <= am_d;
                    as_q   <= as_d;
                    aen_q  <= aen_d;
                    ring_q <= ring_d;
                end
            end

            assign alarm_ring[gi] = ring_q;
        end
    endgenerate

    // Countdown timer next state: load > start > pause, then per-second decrement.
    always_comb begin
        tstate_d = tstate_q;
        tmin_d   = tmin_q;
        tsec_d   = tsec_q;
        tdone_d  = 1'b0;
        if (timer_load) begin
            tmin_d   = timer_min;
            tsec_d   = (timer_sec > 6'd59) ? 6'd59 : timer_sec;
            tstate_d = T_IDLE;
        end else if (timer_start &&
                     (((tstate_q == T_IDLE) && ((tmin_q != 6'd0) || (tsec_q != 6'd0))) ||
                      (tstate_q == T_PAUSE))) begin
            tstate_d = T_RUN;
        end else if (timer_pause && (tstate_q == T_RUN)) begin
            tstate_d = T_PAUSE;
        end else if ((tstate_q == T_RUN) && tick_eff) begin
            if (tsec_q != 6'd0) begin
                tsec_d = tsec_q - 6'd1;
            end else begin
                tsec_d = 6'd59;
                tmin_d = tmin_q - 6'd1;
            end
            if ((tmin_q == 6'd0) && (tsec_q == 6'd1)) begin
                tstate_d = T_DONE;
                tdone_d  = 1'b1;
            end
        end
    end

    // Timer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            tstate_q <= T_IDLE;
            tmin_q   <= 6'd0;
            tsec_q   <= 6'd0;
            tdone_q  <= 1'b0;
        end else begin
            tstate_q <= tstate_d;
            tmin_q   <= tmin_d;
            tsec_q   <= tsec_d;
            tdone_q  <= tdone_d;
        end
    end

    assign hour            = hour_q;
    assign min             = min_q;
    assign sec             = sec_q;
    assign hour12          = (hour_q == 5'd0)  ? 4'd12 :
                             (hour_q > 5'd12)  ? 4'(hour_q - 5'd12) : hour_q[3:0];
    assign pm              = (hour_q >= 5'd12);
    assign day             = day_q;
    assign month           = month_q;
    assign year            = year_q;
    assign day_of_week     = dow_q;
    assign sec_pulse       = sec_pulse_q;
    assign set_err         = set_err_q;
    assign timer_count_min = tmin_q;
    assign timer_count_sec = tsec_q;
    assign timer_state     = tstate_q;
    assign timer_done      = tdone_q;

endmodule

// File: doc/rtc_calendar_multi_alarm.md
Name: rtc_calendar_multi_alarm

Overview:
Parametrised successor to the team's single-alarm clock/calendar. It keeps the time of day and calendar from an internal seconds prescaler and tracks day-of-week incrementally. It adds NUM_ALARMS independently programmable latched alarms, a countdown timer with run/pause control, and validated time setting. It sits between the board clock and the display/buzzer logic.

Parameters:
CLK_DIV, 1, clk cycles per second (>=1)
NUM_ALARMS, 4, number of alarm channels (1..16)
YEAR_MIN, 2020, first calendar year; also the wrap target
YEAR_MAX, 2099, last calendar year
YEAR_MIN_DOW, 3, day-of-week of Jan 1 YEAR_MIN (0=Sun..6=Sat)
SNOOZE_MIN, 5, snooze delay in minutes (used only with RTC_SNOOZE_EN)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
set_en  in  1  load the set_* fields this cycle
set_hour/set_min/set_sec  in  5/6/6  time to load (24 h)
set_day/set_month/set_year/set_dow  in  5/4/12/3  date to load
set_err  out  1  one-cycle pulse: set rejected
alarm_wr  in  1  write one alarm channel
alarm_idx  in  $clog2(NUM_ALARMS) (min 1)  channel to write
alarm_hour/alarm_min/alarm_sec  in  5/6/6  alarm time
alarm_en_in  in  1  enable bit written with the alarm
alarm_ack  in  NUM_ALARMS  per-channel ring clear
timer_load/timer_start/timer_pause  in  1 each  timer controls
timer_min/timer_sec  in  6/6  timer preset
hour/min/sec  out  5/6/6  24 h time
hour12/pm  out  4/1  12 h view (1..12) and PM flag
day/month/year/day_of_week  out  5/4/12/3  calendar
sec_pulse  out  1  high on the first cycle each new second is visible
alarm_ring  out  NUM_ALARMS  latched alarm flags
timer_count_min/timer_count_sec  out  6/6  remaining time
timer_state  out  2  0=IDLE 1=RUN 2=PAUSE 3=DONE
timer_done  out  1  one-cycle pulse when the timer reaches 00:00

Behaviour:
- Reset values:
  - time 00:00:00, date 1/1/YEAR_MIN, day_of_week YEAR_MIN_DOW, hour12=12, pm=0
  - prescaler 0; all alarms disabled at 00:00:00; alarm_ring 0
  - timer IDLE at 00:00; all pulse outputs 0
- Prescaler counts 0..CLK_DIV-1. On the terminal count, time advances by 1 s and sec_pulse is registered high with the new time. With CLK_DIV=1, sec_pulse stays high continuously.
- Rollover chain: sec -> min -> hour -> day (days_in_month with full Gregorian leap rule) -> month -> year.
  - day_of_week = (day_of_week+1) mod 7 on each day rollover.
  - Dec 31 YEAR_MAX 23:59:59 -> Jan 1 YEAR_MIN 00:00:00 with day_of_week = YEAR_MIN_DOW.
- hour12/pm are combinational from hour: 0->12 AM, 12->12 PM, 13..23 -> 1..11 PM.
- set_en validation:
  - Load is applied only if hour<=23, min<=59, sec<=59, 1<=month<=12, 1<=day<=days_in_month(month,year), YEAR_MIN<=year<=YEAR_MAX, and dow<=6.
  - A valid load writes all fields, clears the prescaler, and suppresses that cycle's tick.
  - An invalid load leaves state unchanged and pulses set_err.
  - set_en has priority over a tick in the same cycle.
- alarm_wr writes time and enable to channel alarm_idx and clears that channel's ring. Out-of-range alarm_idx is ignored.
- Alarm match: on a sec_pulse cycle, every enabled channel whose time equals hour/min/sec sets its ring bit on the next cycle.
  - Rings stay latched until alarm_ack[i], alarm_wr to channel i, or reset.
  - Setting the time directly onto an alarm time never triggers.
  - A new match in the same cycle as alarm_ack wins (ring stays 1).
- Timer priority is load > start > pause.
  - load (any state): preset the count, go to IDLE.
  - start: IDLE with a nonzero count -> RUN; PAUSE -> RUN; ignored otherwise.
  - pause: RUN -> PAUSE.
  - In RUN, each second tick decrements mm:ss (borrowing ss 0 -> 59, mm-1).
  - The decrement reaching 00:00 enters DONE and pulses timer_done in the same cycle.
  - timer_sec>59 at load saturates to 59.

Optional Feature:
RTC_SNOOZE_EN: adds input alarm_snooze[NUM_ALARMS].
- With the macro: snooze on a ringing channel clears the ring. The channel re-rings SNOOZE_MIN minutes later (wrapping past midnight), once per snooze. alarm_ack cancels a pending snooze.
- Without the macro: the port is absent and alarm behaviour is exactly as in Behaviour.

Test Plan:
1. CLK_DIV=4, reset, run 240 cycles -> min=1, sec=0, 60 sec_pulse pulses, hour12=12, pm=0.
2. Leap handling:
   - Set 2024-02-28 23:59:59 dow=3 -> after one tick: 2024-02-29, dow=4.
   - Set 2023-02-28 23:59:59 -> 2023-03-01.
3. Year wrap: set 2099-12-31 23:59:59 dow=4 -> 2020-01-01 00:00:00, dow=3.
4. Alarm 2 = 07:30:00 enabled; set 07:29:58 -> alarm_ring=4'b0100 one cycle after the second sec_pulse, held until alarm_ack[2].
5. Timer: load 01:05, start, pause at 01:02 for 10 s, resume -> timer_done pulses after 65 RUN seconds, state DONE, count 00:00.
6. Set with hour=24 or day=31 month=4 -> set_err one-cycle pulse, time/date unchanged, ticking continues.
